// File: rtl/alu_pipe.sv
// Two-stage RV32I integer/branch/jump execution unit feeding the common result bus.
// Optional ALU_PERF_EN adds perf_ops/perf_taken retirement counters.
module alu_pipe (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        rollback,
   input  logic        in_config,
   input  logic [31:0] in_value_1,
   input  logic [31:0] in_value_2,
   input  logic [31:0] in_value_pc,
   input  logic [6:0]  in_opcode,
   input  logic [2:0]  in_precise,
   input  logic        in_more_precise,
   input  logic [31:0] in_imm,
   input  logic [3:0]  in_rob_entry,
   output logic        out_config,
   output logic [31:0] out_val,
   output logic [3:0]  out_rob_entry,
   output logic        out_branch,
   output logic        out_taken,
   output logic [31:0] out_target
`ifdef ALU_PERF_EN
   ,
   output logic [31:0] perf_ops,
   output logic [31:0] perf_taken
`endif
);

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   function automatic logic [31:0] alu_op(input logic [2:0] f3, input logic sub, input logic sra,
                                          input logic [31:0] a, input logic [31:0] b);
      logic signed [31:0] sa;
      logic signed [31:0] sb;
      sa = $signed(a);
      sb = $signed(b);
      case (f3)
         3'b000:  alu_op = sub ? (a - b) : (a + b);
         3'b001:  alu_op = a << b[4:0];
         3'b010:  alu_op = (sa < sb) ? 32'd1 : 32'd0;
         3'b011:  alu_op = (a < b) ? 32'd1 : 32'd0;
         3'b100:  alu_op = a ^ b;
         3'b101:  alu_op = sra ? 32'(sa >>> b[4:0]) : (a >> b[4:0]);
         3'b110:  alu_op = a | b;
         default: alu_op = a & b;
      endcase
   endfunction

   function automatic logic br_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      case (f3)
         3'b000:  br_taken = (a == b);
         3'b001:  br_taken = (a != b);
         3'b100:  br_taken = ($signed(a) < $signed(b));
         3'b101:  br_taken = ($signed(a) >= $signed(b));
         3'b110:  br_taken = (a < b);
         3'b111:  br_taken = (a >= b);
         default: br_taken = 1'b0;
      endcase
   endfunction

   logic        s1_valid_q;
   logic [31:0] s1_v1_q, s1_v2_q, s1_pc_q, s1_imm_q;
   logic [6:0]  s1_op_q;
   logic [2:0]  s1_f3_q;
   logic        s1_mp_q;
   logic [3:0]  s1_rob_q;

   logic        out_config_q, out_branch_q, out_taken_q;
   logic [31:0] out_val_q, out_target_q;
   logic [3:0]  out_rob_q;

   logic        val_branch_d, taken_d;
   logic [31:0] val_d, target_d, op2, pc4;
   logic        advance, load, emit;

   // Rollback overrides rdy; data registers only move on a live advance.
   assign advance = rdy & ~rollback;
   assign load    = advance & in_config;
   assign emit    = advance & s1_valid_q;

   // Stage 1: issue latch
   always_ff @(posedge clk) begin
      if (load) begin
         s1_v1_q  <= in_value_1;
         s1_v2_q  <= in_value_2;
         s1_pc_q  <= in_value_pc;
         s1_imm_q <= in_imm;
         s1_op_q  <= in_opcode;
         s1_f3_q  <= in_precise;
         s1_mp_q  <= in_more_precise;
         s1_rob_q <= in_rob_entry;
      end
   end

   // Stage 2: execute
   always_comb begin
      op2          = (s1_op_q == OPC_OP) ? s1_v2_q : s1_imm_q;
      pc4          = s1_pc_q + 32'd4;
      val_d        = 32'd0;
      val_branch_d = 1'b0;
      taken_d      = 1'b0;
      target_d     = pc4;
      case (s1_op_q)
         OPC_LUI:   val_d = s1_imm_q;
         OPC_AUIPC: val_d = s1_pc_q + s1_imm_q;
         OPC_JAL: begin
            val_d = pc4; val_branch_d = 1'b1; taken_d = 1'b1;
            target_d = s1_pc_q + s1_imm_q;
         end
         OPC_JALR: begin
            val_d = pc4; val_branch_d = 1'b1; taken_d = 1'b1;
            target_d = (s1_v1_q + s1_imm_q) & ~32'd1;
         end
         OPC_BRANCH: begin
            val_branch_d = 1'b1;
            taken_d      = br_taken(s1_f3_q, s1_v1_q, s1_v2_q);
            target_d     = s1_pc_q + s1_imm_q;
         end
         // Bit 30 selects SUB only for register-register ops; ADDI ignores it.
         OPC_OPIMM: val_d = alu_op(s1_f3_q, 1'b0, s1_mp_q, s1_v1_q, op2);
         OPC_OP:    val_d = alu_op(s1_f3_q, s1_mp_q, s1_mp_q, s1_v1_q, op2);
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_valid_q   <= 1'b0;
         out_config_q <= 1'b0;
         out_val_q    <= 32'd0;
         out_rob_q    <= 4'd0;
         out_branch_q <= 1'b0;
         out_taken_q  <= 1'b0;
         out_target_q <= 32'd0;
      end else if (rollback) begin
         s1_valid_q   <= 1'b0;
         out_config_q <= 1'b0;
      end else if (rdy) begin
         s1_valid_q   <= in_config;
         out_config_q <= s1_valid_q;
         if (emit) begin
            out_val_q    <= val_d;
            out_rob_q    <= s1_rob_q;
            out_branch_q <= val_branch_d;
            out_taken_q  <= taken_d;
            out_target_q <= target_d;
         end
      end
   end

`ifdef ALU_PERF_EN
   logic [31:0] perf_ops_q, perf_taken_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_ops_q   <= 32'd0;
         perf_taken_q <= 32'd0;
      end else if (emit) begin
         perf_ops_q <= perf_ops_q + 32'd1;
         if (taken_d) perf_taken_q <= perf_taken_q + 32'd1;
      end
   end

   assign perf_ops   = perf_ops_q;
   assign perf_taken = perf_taken_q;
`endif

   assign out_config    = out_config_q;
   assign out_val       = out_val_q;
   assign out_rob_entry = out_rob_q;
   assign out_branch    = out_branch_q;
   assign out_taken     = out_taken_q;
   assign out_target    = out_target_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: reset, ALU/branch/jump results, rollback, rdy freeze, mid-pipe reset.
module tb_alu_pipe;

   logic        clk = 1'b0;
   logic        rst, rdy, rollback, in_config;
   logic [31:0] in_value_1, in_value_2, in_value_pc, in_imm;
   logic [6:0]  in_opcode;
   logic [2:0]  in_precise;
   logic        in_more_precise;
   logic [3:0]  in_rob_entry;
   logic        out_config, out_branch, out_taken;
   logic [31:0] out_val, out_target;
   logic [3:0]  out_rob_entry;
`ifdef ALU_PERF_EN
   logic [31:0] perf_ops, perf_taken;
   logic [31:0] perf_snap;
`endif

   int checks = 0;
   int errors = 0;

   alu_pipe dut (
      .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback), .in_config(in_config),
      .in_value_1(in_value_1), .in_value_2(in_value_2), .in_value_pc(in_value_pc),
      .in_opcode(in_opcode), .in_precise(in_precise), .in_more_precise(in_more_precise),
      .in_imm(in_imm), .in_rob_entry(in_rob_entry),
      .out_config(out_config), .out_val(out_val), .out_rob_entry(out_rob_entry),
      .out_branch(out_branch), .out_taken(out_taken), .out_target(out_target)
`ifdef ALU_PERF_EN
      , .perf_ops(perf_ops), .perf_taken(perf_taken)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic mp,
                        input logic [31:0] v1, input logic [31:0] v2, input logic [31:0] pc,
                        input logic [31:0] imm, input logic [3:0] rob);
      in_config = 1'b1; in_opcode = op; in_precise = f3; in_more_precise = mp;
      in_value_1 = v1; in_value_2 = v2; in_value_pc = pc; in_imm = imm; in_rob_entry = rob;
   endtask

   task automatic idle();
      in_config = 1'b0;
   endtask

   initial begin
      rst = 1'b1; rdy = 1'b1; rollback = 1'b0; in_config = 1'b0;
      in_value_1 = '0; in_value_2 = '0; in_value_pc = '0; in_imm = '0;
      in_opcode = '0; in_precise = '0; in_more_precise = 1'b0; in_rob_entry = '0;
      #2 rst = 1'b0;
      #1;
      chk("rst_config", out_config, 0);
      chk("rst_val", out_val, 0);
      chk("rst_rob", out_rob_entry, 0);
      chk("rst_branch", out_branch, 0);
      chk("rst_taken", out_taken, 0);
      chk("rst_target", out_target, 0);
      step();
      @(negedge clk) rst = 1'b1;
      step();
      chk("idle_config", out_config, 0);

      // ADDI with bit30 set: still an add
      issue(7'b0010011, 3'b000, 1'b1, 32'd5, 32'd0, 32'h200, 32'hFFFFFFF9, 4'd3);
      step(); idle();
      chk("addi_latency", out_config, 0);
      step();
      chk("addi_config", out_config, 1);
      chk("addi_val", out_val, 32'hFFFFFFFE);
      chk("addi_rob", out_rob_entry, 3);
      chk("addi_branch", out_branch, 0);
      chk("addi_taken", out_taken, 0);
      chk("addi_target", out_target, 32'h204);
      step();
      chk("addi_pulse_end", out_config, 0);

      // Back-to-back SUB, SRA, SLTU
      issue(7'b0110011, 3'b000, 1'b1, 32'd10, 32'd3, 32'h0, 32'h0, 4'd5);
      step();
      issue(7'b0110011, 3'b101, 1'b1, 32'h80000000, 32'd4, 32'h0, 32'h0, 4'd6);
      step();
      chk("sub_config", out_config, 1);
      chk("sub_val", out_val, 32'd7);
      chk("sub_rob", out_rob_entry, 5);
      issue(7'b0110011, 3'b011, 1'b0, 32'd1, 32'hFFFFFFFF, 32'h0, 32'h0, 4'd7);
      step(); idle();
      chk("sra_config", out_config, 1);
      chk("sra_val", out_val, 32'hF8000000);
      chk("sra_rob", out_rob_entry, 6);
      step();
      chk("sltu_config", out_config, 1);
      chk("sltu_val", out_val, 32'd1);
      chk("sltu_rob", out_rob_entry, 7);
      step();
      chk("b2b_end", out_config, 0);

      // SRAI: shamt from imm[4:0], imm carries bit 10
      issue(7'b0010011, 3'b101, 1'b1, 32'hF0000000, 32'h0, 32'h0, 32'h404, 4'd8);
      step(); idle(); step();
      chk("srai_val", out_val, 32'hFF000000);

      // BLT signed taken, then BLTU same operands not taken
      issue(7'b1100011, 3'b100, 1'b0, 32'hFFFFFFFF, 32'd1, 32'h100, 32'h20, 4'd1);
      step();
      issue(7'b1100011, 3'b110, 1'b0, 32'hFFFFFFFF, 32'd1, 32'h100, 32'h20, 4'd2);
      step(); idle();
      chk("blt_config", out_config, 1);
      chk("blt_branch", out_branch, 1);
      chk("blt_taken", out_taken, 1);
      chk("blt_target", out_target, 32'h120);
      chk("blt_val", out_val, 0);
      step();
      chk("bltu_branch", out_branch, 1);
      chk("bltu_taken", out_taken, 0);
      chk("bltu_target", out_target, 32'h120);

      // JALR clears target bit 0
      issue(7'b1100111, 3'b000, 1'b0, 32'h1003, 32'h0, 32'h40, 32'd4, 4'd4);
      step(); idle(); step();
      chk("jalr_val", out_val, 32'h44);
      chk("jalr_target", out_target, 32'h1006);
      chk("jalr_taken", out_taken, 1);
      chk("jalr_branch", out_branch, 1);

      // JAL
      issue(7'b1101111, 3'b000, 1'b0, 32'h0, 32'h0, 32'h1000, 32'hFFFFFFF0, 4'd12);
      step(); idle(); step();
      chk("jal_val", out_val, 32'h1004);
      chk("jal_target", out_target, 32'hFF0);
      chk("jal_taken", out_taken, 1);

      // AUIPC and LUI
      issue(7'b0010111, 3'b000, 1'b0, 32'h0, 32'h0, 32'h80, 32'h12345000, 4'd13);
      step();
      issue(7'b0110111, 3'b000, 1'b0, 32'h0, 32'h0, 32'h0, 32'hABCDE000, 4'd14);
      step(); idle();
      chk("auipc_val", out_val, 32'h12345080);
      step();
      chk("lui_val", out_val, 32'hABCDE000);

      // Unknown opcode still completes
      issue(7'b1111111, 3'b000, 1'b0, 32'h55, 32'h66, 32'h300, 32'h77, 4'd15);
      step(); idle(); step();
      chk("unk_config", out_config, 1);
      chk("unk_val", out_val, 0);
      chk("unk_branch", out_branch, 0);
      chk("unk_taken", out_taken, 0);
      chk("unk_target", out_target, 32'h304);
      chk("unk_rob", out_rob_entry, 15);

      // Rollback as the first of two instructions reaches stage 2
      issue(7'b0010011, 3'b000, 1'b0, 32'd1, 32'd0, 32'h0, 32'd1, 4'd9);
      step();
      issue(7'b0010011, 3'b000, 1'b0, 32'd2, 32'd0, 32'h0, 32'd2, 4'd10);
      rollback = 1'b1;
      step();
      rollback = 1'b0;
      chk("rb_first_dropped", out_config, 0);
      issue(7'b0110111, 3'b000, 1'b0, 32'h0, 32'h0, 32'h0, 32'hABC00000, 4'd11);
      step(); idle();
      chk("rb_second_dropped", out_config, 0);
      step();
      chk("rb_next_config", out_config, 1);
      chk("rb_next_val", out_val, 32'hABC00000);
      chk("rb_next_rob", out_rob_entry, 11);
      step();
      chk("rb_next_end", out_config, 0);

      // rdy freeze with one result on the bus and one in stage 1
      issue(7'b0110111, 3'b000, 1'b0, 32'h0, 32'h0, 32'h0, 32'h11110000, 4'd1);
      step();
      issue(7'b0110111, 3'b000, 1'b0, 32'h0, 32'h0, 32'h0, 32'h22220000, 4'd2);
      step();
      chk("frz_a_config", out_config, 1);
      chk("frz_a_val", out_val, 32'h11110000);
      rdy = 1'b0;
      issue(7'b0110111, 3'b000, 1'b0, 32'h0, 32'h0, 32'h0, 32'h33330000, 4'd15);
`ifdef ALU_PERF_EN
      perf_snap = perf_ops;
`endif
      for (int i = 0; i < 3; i++) begin
         step();
         chk("frz_hold_config", out_config, 1);
         chk("frz_hold_val", out_val, 32'h11110000);
         chk("frz_hold_rob", out_rob_entry, 1);
      end
      rdy = 1'b1; idle();
      step();
      chk("frz_b_config", out_config, 1);
      chk("frz_b_val", out_val, 32'h22220000);
      chk("frz_b_rob", out_rob_entry, 2);
`ifdef ALU_PERF_EN
      chk("frz_perf_ops", perf_ops, perf_snap + 32'd1);
`endif
      step();
      chk("frz_b_end", out_config, 0);
      step();
      chk("frz_no_ghost", out_config, 0);

      // Asynchronous reset with an instruction in flight
      issue(7'b0110111, 3'b000, 1'b0, 32'h0, 32'h0, 32'h0, 32'h44440000, 4'd6);
      step(); idle();
      rst = 1'b0;
      #2;
      chk("mid_rst_config", out_config, 0);
      chk("mid_rst_val", out_val, 0);
      rst = 1'b1;
      step();
      chk("post_rst_c1", out_config, 0);
      step();
      chk("post_rst_c2", out_config, 0);
`ifdef ALU_PERF_EN
      chk("post_rst_perf", perf_ops, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Two-stage execution unit that sits directly downstream of the reservation station. It accepts one ready instruction per cycle and computes the RV32I integer, branch and jump result. It broadcasts the value with its ROB tag on the common result bus that feeds the reservation station, the ROB and the register-status logic. For control-flow instructions it also reports the resolved branch outcome and target to the ROB.

## Interface
- No parameters.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `rdy` in 1: global enable; low freezes all state.
- `rollback` in 1: misprediction flush.
- `in_config` in 1: valid instruction from the reservation station this cycle.
- `in_value_1` in 32: rs1 operand.
- `in_value_2` in 32: rs2 operand.
- `in_value_pc` in 32: instruction PC.
- `in_opcode` in 7: instruction opcode.
- `in_precise` in 3: funct3.
- `in_more_precise` in 1: instruction bit 30 (SUB/SRA/SRAI select).
- `in_imm` in 32: sign-extended immediate; for U-type it is already shifted.
- `in_rob_entry` in 4: destination ROB tag.
- `out_config` out 1: result valid, one-cycle pulse per instruction.
- `out_val` out 32: result value.
- `out_rob_entry` out 4: ROB tag of the result.
- `out_branch` out 1: result belongs to JAL, JALR or BRANCH.
- `out_taken` out 1: control transfer taken.
- `out_target` out 32: resolved target PC.

## Operation
- Stage 1 (issue latch): on an edge with `in_config`=1, latch all `in_*` fields and set `s1_valid`. With `in_config`=0, clear `s1_valid`.
- Stage 2 (execute): compute from the stage-1 registers and register the result into the `out_*` registers. `out_config` <= `s1_valid`.
- Opcode behaviour:
  - LUI 0110111: val = imm.
  - AUIPC 0010111: val = pc + imm.
  - JAL 1101111: val = pc+4; target = pc+imm; taken = 1.
  - JALR 1100111: val = pc+4; target = (v1+imm) & ~1; taken = 1.
  - BRANCH 1100011: val = 0; target = pc+imm; taken from funct3. BEQ 000, BNE 001, BLT 100 and BGE 101 are signed; BLTU 110 and BGEU 111 are unsigned. Any other funct3 gives taken = 0.
  - OP-IMM 0010011: operands are v1 and imm. funct3 ADD/SLT/SLTU/XOR/OR/AND/SLL/SRL-SRA. `in_more_precise` is honoured only for funct3 101 (SRAI); it is ignored for ADDI.
  - OP 0110011: operands are v1 and v2. funct3 000 with `more_precise`=1 gives SUB.
- Shift amount is operand2[4:0]. SLT/SLTU produce 32'h0/32'h1.
- All arithmetic is mod 2^32.
- Unknown opcode: val = 0, branch = 0, taken = 0; `out_config` still pulses so the ROB entry completes.
- When `out_branch` = 0: `out_taken` = 0 and `out_target` = pc+4.

## Timing
- Latency is 2 cycles. An instruction sampled at edge N has `out_config`=1 during the cycle after edge N+1. Throughput is 1 per cycle with no backpressure.
- Reset (`rst`=0, asynchronous): `s1_valid`=0, `out_config`=0, `out_val`=0, `out_rob_entry`=0, `out_branch`=0, `out_taken`=0, `out_target`=0.
- `rollback`=1 at an edge, regardless of `rdy`:
  - `s1_valid` and `out_config` are cleared.
  - The `in_config` of that cycle is discarded.
  - Data registers keep their old values.
- `rdy`=0 (and no rollback): every register holds, including `out_config`. Consumers gate on `rdy` themselves.
- `rollback` is sampled before `in_config`. The first instruction accepted after a rollback appears 2 cycles later.
- Reset asserted mid-pipeline drops all in-flight instructions. No result is emitted after reset release until a new `in_config`.

## Configuration
- `ALU_PERF_EN` defined:
  - Adds output ports `perf_ops` [31:0] (count of `out_config` pulses) and `perf_taken` [31:0] (count of pulses with `out_taken`=1).
  - Counters increment at the same edge that sets the output and only when `rdy`=1.
  - Reset to 0 by `rst`; not cleared by `rollback`; wrap from 32'hFFFFFFFF to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

## Test plan
- ADDI, v1=5, imm=-7, rob=3 -> two cycles later `out_config`=1, `out_val`=32'hFFFFFFFE, `out_rob_entry`=3, `out_branch`=0.
- Back-to-back SUB (v1=10, v2=3), SRA (v1=32'h80000000, v2=4), SLTU (v1=1, v2=32'hFFFFFFFF) on consecutive cycles -> three consecutive pulses with 7, 32'hF8000000, 1.
- BLT, v1=-1, v2=1, pc=32'h100, imm=32'h20 -> `out_branch`=1, `out_taken`=1, `out_target`=32'h120, `out_val`=0. BLTU with the same operands -> `out_taken`=0.
- JALR, v1=32'h1003, imm=4, pc=32'h40 -> `out_val`=32'h44, `out_target`=32'h1006, `out_taken`=1.
- Issue 2 instructions, assert `rollback` on the cycle the first reaches stage 2 -> no `out_config` pulse for either. An instruction issued the next cycle emits normally.
- Hold `rdy`=0 for 3 cycles with a pulse pending -> outputs frozen. After `rdy` returns, `out_config` is high for exactly one cycle. With `ALU_PERF_EN`, `perf_ops` advances by exactly one.
